pepper_scheduler: RTL and testbench

//   Sequences the chef's pepper weapon: debounces the throw key into one request,

---
 rtl/pepper_scheduler.sv | 153 +++++++++++++++
 tb/tb_pepper_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pepper_scheduler.sv
// Pepper weapon sequencer: one debounced throw per key press, inventory with
// bonus refills, spray/cooldown timing and per-enemy stun timers, per frame.
module pepper_scheduler #(
  parameter logic [7:0]  KEY_PEPPER      = 8'd19,
  parameter int unsigned PEPPER_INIT     = 5,
  parameter int unsigned PEPPER_MAX      = 9,
  parameter int unsigned SPRAY_FRAMES    = 16,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned STUN_FRAMES     = 600,
  parameter int unsigned HIT_DX          = 24,
  parameter int unsigned HIT_DY          = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       chef_dir,
  input  logic [9:0] ChefX,
  input  logic [9:0] ChefY,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  input  logic [9:0] Enemy1X,
  input  logic [9:0] Enemy1Y,
  input  logic       bonus_pickup,
  output logic [3:0] pepper_count,
  output logic       have_pepper,
  output logic       spraying,
  output logic       spray_dir,
  output logic       sausage_hit,
  output logic       egg_hit
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPRAY    = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  localparam int unsigned CNT_W =
    $clog2(((SPRAY_FRAMES > COOLDOWN_FRAMES) ? SPRAY_FRAMES : COOLDOWN_FRAMES) + 1);
  localparam logic [CNT_W-1:0] SPRAY_LAST = CNT_W'(SPRAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [3:0]       CNT_INIT   = 4'(PEPPER_INIT);
  localparam logic [4:0]       CNT_MAX    = 5'(PEPPER_MAX);
  localparam logic [9:0]       STUN_LOAD  = 10'(STUN_FRAMES);
  localparam logic [10:0]      DX         = 11'(HIT_DX);
  localparam logic [10:0]      DY         = 11'(HIT_DY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]       pepper_count_q, pepper_count_d;
  logic             spray_dir_q, spray_dir_d;
  logic             key_prev_q;
  logic [9:0]       saus_tmr_q, saus_tmr_d;
  logic [9:0]       egg_tmr_q, egg_tmr_d;

  logic       key_now;
  logic       req;
  logic       can_throw;
  logic       throw;
  logic       saus_in;
  logic       egg_in;
  logic [4:0] cnt_sum;

  // Spray reach test, widened to 11 bits so ChefX+DX cannot wrap and the
  // left edge clamps at zero instead of wrapping to the far right.
  function automatic logic in_window(input logic [9:0] ex, input logic [9:0] ey,
                                     input logic [9:0] cx, input logic [9:0] cy,
                                     input logic dir);
    logic [10:0] ex_w, ey_w, cx_w, cy_w, dy, lo;
    ex_w = {1'b0, ex};
    ey_w = {1'b0, ey};
    cx_w = {1'b0, cx};
    cy_w = {1'b0, cy};
    dy   = (ey_w >= cy_w) ? (ey_w - cy_w) : (cy_w - ey_w);
    lo   = (cx_w >= DX) ? (cx_w - DX) : 11'd0;
    if (dir) in_window = (dy <= DY) && (ex_w >= cx_w) && (ex_w <= cx_w + DX);
    else     in_window = (dy <= DY) && (ex_w >= lo) && (ex_w <= cx_w);
  endfunction

  assign key_now   = (keycode == KEY_PEPPER);
  assign req       = key_now && !key_prev_q;
  assign can_throw = req && (pepper_count_q != 4'd0);
  assign saus_in   = in_window(EnemyX, EnemyY, ChefX, ChefY, spray_dir_q);
  assign egg_in    = in_window(Enemy1X, Enemy1Y, ChefX, ChefY, spray_dir_q);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (can_throw)                 state_d = SPRAY;
      SPRAY:    if (frame_cnt_q == SPRAY_LAST) state_d = COOLDOWN;
      COOLDOWN: if (frame_cnt_q == COOL_LAST)  state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  always_comb begin
    spraying = (state_q == SPRAY);
    throw    = (state_q == IDLE) && can_throw;
  end

  always_comb begin
    frame_cnt_d = '0;
    if (state_q != IDLE && state_d == state_q) frame_cnt_d = frame_cnt_q + 1'b1;

    spray_dir_d = throw ? chef_dir : spray_dir_q;

    // Throw and bonus on the same edge cancel; a bonus at the ceiling is lost.
    cnt_sum        = {1'b0, pepper_count_q} + {4'd0, bonus_pickup} - {4'd0, throw};
    pepper_count_d = (cnt_sum > CNT_MAX) ? CNT_MAX[3:0] : cnt_sum[3:0];

    saus_tmr_d = saus_tmr_q;
    if (spraying && saus_in)     saus_tmr_d = STUN_LOAD;
    else if (saus_tmr_q != 10'd0) saus_tmr_d = saus_tmr_q - 10'd1;

    egg_tmr_d = egg_tmr_q;
    if (spraying && egg_in)      egg_tmr_d = STUN_LOAD;
    else if (egg_tmr_q != 10'd0) egg_tmr_d = egg_tmr_q - 10'd1;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt_q    <= '0;
      pepper_count_q <= CNT_INIT;
      spray_dir_q    <= 1'b0;
      key_prev_q     <= 1'b0;
      saus_tmr_q     <= 10'd0;
      egg_tmr_q      <= 10'd0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      pepper_count_q <= pepper_count_d;
      spray_dir_q    <= spray_dir_d;
      key_prev_q     <= key_now;
      saus_tmr_q     <= saus_tmr_d;
      egg_tmr_q      <= egg_tmr_d;
    end
  end

  assign pepper_count = pepper_count_q;
  assign have_pepper  = (pepper_count_q != 4'd0);
  assign spray_dir    = spray_dir_q;
  assign sausage_hit  = (saus_tmr_q != 10'd0);
  assign egg_hit      = (egg_tmr_q != 10'd0);

endmodule

// File: tb/tb_pepper_scheduler.sv
// Bench for pepper_scheduler: hit-window vector table, directed multi-frame
// sequences and a randomized run, all against a frame-indexed event model.
module tb_pepper_scheduler;

  localparam int SPRAY = 16;
  localparam int COOL  = 30;
  localparam int STUN  = 600;
  localparam int PMAX  = 9;
  localparam int PINIT = 5;
  localparam int DXM   = 24;
  localparam int DYM   = 4;

  logic       frame_clk, Reset, chef_dir, bonus_pickup;
  logic [7:0] keycode;
  logic [9:0] ChefX, ChefY, EnemyX, EnemyY, Enemy1X, Enemy1Y;
  logic [3:0] pepper_count;
  logic       have_pepper, spraying, spray_dir, sausage_hit, egg_hit;

  int n_checks = 0;
  int n_errors = 0;

  // Model keeps frame indices of events rather than counters.
  int k = 0;
  int m_last_throw, m_count, m_saus_at, m_egg_at;
  bit m_key_prev, m_dir;

  typedef struct {
    logic dir;
    int   cx, cy, ex, ey;
    logic exp_hit;
  } win_vec_t;
  win_vec_t vecs[10];

  pepper_scheduler dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .chef_dir     (chef_dir),
    .ChefX        (ChefX),
    .ChefY        (ChefY),
    .EnemyX       (EnemyX),
    .EnemyY       (EnemyY),
    .Enemy1X      (Enemy1X),
    .Enemy1Y      (Enemy1Y),
    .bonus_pickup (bonus_pickup),
    .pepper_count (pepper_count),
    .have_pepper  (have_pepper),
    .spraying     (spraying),
    .spray_dir    (spray_dir),
    .sausage_hit  (sausage_hit),
    .egg_hit      (egg_hit)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (frame %0d)", name, act, exp, k);
    end
  endtask

  function automatic bit m_in_window(int ex, int ey, int cx, int cy, bit dir);
    int lo;
    int dy;
    dy = (ey > cy) ? ey - cy : cy - ey;
    lo = cx - DXM;
    if (lo < 0) lo = 0;
    if (dy > DYM) return 1'b0;
    if (dir) return (ex >= cx) && (ex <= cx + DXM);
    return (ex >= lo) && (ex <= cx);
  endfunction

  task automatic m_reset();
    m_last_throw = -100000;
    m_count      = PINIT;
    m_saus_at    = -100000;
    m_egg_at     = -100000;
    m_key_prev   = 1'b0;
    m_dir        = 1'b0;
  endtask

  task automatic model_edge();
    bit req, idle_before, spray_before, thr;
    k++;
    spray_before = (k - 1 >= m_last_throw) && (k - 1 <= m_last_throw + SPRAY - 1);
    if (spray_before) begin
      if (m_in_window(int'(EnemyX), int'(EnemyY), int'(ChefX), int'(ChefY), m_dir))   m_saus_at = k;
      if (m_in_window(int'(Enemy1X), int'(Enemy1Y), int'(ChefX), int'(ChefY), m_dir)) m_egg_at  = k;
    end
    req         = (keycode == 8'd19) && !m_key_prev;
    m_key_prev  = (keycode == 8'd19);
    idle_before = (k - 1) >= m_last_throw + SPRAY + COOL;
    thr         = req && idle_before && (m_count > 0);
    if (thr) begin
      m_last_throw = k;
      m_dir        = chef_dir;
    end
    m_count = m_count - int'(thr) + int'(bonus_pickup);
    if (m_count > PMAX) m_count = PMAX;
  endtask

  task automatic compare_all();
    check("count", 32'(pepper_count), 32'(m_count));
    check("have_pepper", 32'(have_pepper), 32'(m_count != 0));
    check("spraying", 32'(spraying), 32'((k >= m_last_throw) && (k <= m_last_throw + SPRAY - 1)));
    check("spray_dir", 32'(spray_dir), 32'(m_dir));
    check("sausage_hit", 32'(sausage_hit), 32'(k <= m_saus_at + STUN - 1));
    check("egg_hit", 32'(egg_hit), 32'(k <= m_egg_at + STUN - 1));
  endtask

  task automatic step();
    @(posedge frame_clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called just after an edge; reset is pulsed and released before the next edge.
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("rst_spraying", 32'(spraying), 32'd0);
    check("rst_saus", 32'(sausage_hit), 32'd0);
    check("rst_egg", 32'(egg_hit), 32'd0);
    check("rst_count", 32'(pepper_count), 32'(PINIT));
    check("rst_have", 32'(have_pepper), 32'd1);
    check("rst_dir", 32'(spray_dir), 32'd0);
    m_reset();
    #1;
    Reset = 1'b0;
  endtask

  task automatic throw_and_wait(input int frames);
    keycode = 8'd19;
    step();
    keycode = 8'd0;
    steps(frames);
  endtask

  initial begin
    int spray_cnt, hit_cnt;
    int cx, cy, ex, ey, e1x, e1y;

    Reset = 1'b1; keycode = 8'd0; chef_dir = 1'b0; bonus_pickup = 1'b0;
    ChefX = 10'd100; ChefY = 10'd200;
    EnemyX = 10'd600; EnemyY = 10'd600; Enemy1X = 10'd700; Enemy1Y = 10'd700;
    m_reset();
    @(posedge frame_clk);
    #1;
    do_reset();

    // Single throw: spray length and single-hit stun length.
    chef_dir = 1'b1; EnemyX = 10'd110; EnemyY = 10'd200; keycode = 8'd19;
    step();
    check("t1_count", 32'(pepper_count), 32'd4);
    check("t1_spray_on", 32'(spraying), 32'd1);
    keycode = 8'd0;
    spray_cnt = 1;
    hit_cnt = 0;
    for (int i = 1; i <= 700; i++) begin
      step();
      if (i == 1) EnemyX = 10'd400;
      if (spraying) spray_cnt++;
      if (sausage_hit) hit_cnt++;
    end
    check("t1_spray_frames", 32'(spray_cnt), 32'(SPRAY));
    check("t1_stun_frames", 32'(hit_cnt), 32'(STUN));

    // Held key yields one throw; cooldown presses dropped, frame 48 accepted.
    keycode = 8'd19;
    steps(100);
    check("t2_hold_count", 32'(pepper_count), 32'd3);
    keycode = 8'd0;
    steps(60);
    keycode = 8'd19;
    step();
    check("t2_throw_count", 32'(pepper_count), 32'd2);
    for (int r = 1; r <= 48; r++) begin
      keycode = (r == 30 || r == 46 || r == 48) ? 8'd19 : 8'd0;
      step();
      if (r == 30) check("t2_cool_press_spray", 32'(spraying), 32'd0);
      if (r == 46) check("t2_late_cool_count", 32'(pepper_count), 32'd2);
      if (r == 48) begin
        check("t2_accept_count", 32'(pepper_count), 32'd1);
        check("t2_accept_spray", 32'(spraying), 32'd1);
      end
    end
    keycode = 8'd0;
    steps(50);

    // Empty inventory, saturation, throw+bonus on the same edge.
    throw_and_wait(50);
    check("t4_empty_count", 32'(pepper_count), 32'd0);
    check("t4_empty_have", 32'(have_pepper), 32'd0);
    keycode = 8'd19;
    step();
    check("t4_empty_press", 32'(spraying), 32'd0);
    keycode = 8'd0;
    for (int i = 0; i < 10; i++) begin
      bonus_pickup = 1'b1;
      step();
      bonus_pickup = 1'b0;
      step();
    end
    check("t4_saturate", 32'(pepper_count), 32'(PMAX));
    do_reset();
    throw_and_wait(50);
    throw_and_wait(50);
    check("t4_count3", 32'(pepper_count), 32'd3);
    keycode = 8'd19; bonus_pickup = 1'b1;
    step();
    check("t4_net_zero", 32'(pepper_count), 32'd3);
    check("t4_net_spray", 32'(spraying), 32'd1);
    keycode = 8'd0; bonus_pickup = 1'b0;
    steps(50);

    // Hit-window geometry table (egg only; sausage parked out of range).
    vecs[0] = '{1'b0, 100, 100, 110, 100, 1'b0};
    vecs[1] = '{1'b0, 100, 100,  76, 104, 1'b1};
    vecs[2] = '{1'b0, 100, 100,  76, 105, 1'b0};
    vecs[3] = '{1'b0,  10,  50,   0,  50, 1'b1};
    vecs[4] = '{1'b0, 100, 100,  75, 100, 1'b0};
    vecs[5] = '{1'b1, 100, 100, 124,  96, 1'b1};
    vecs[6] = '{1'b1, 100, 100, 125, 100, 1'b0};
    vecs[7] = '{1'b1, 100, 100,  99, 100, 1'b0};
    vecs[8] = '{1'b1, 1010, 500, 1023, 500, 1'b1};
    vecs[9] = '{1'b0, 100, 100, 100,  96, 1'b1};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      chef_dir = vecs[i].dir;
      ChefX = 10'(vecs[i].cx); ChefY = 10'(vecs[i].cy);
      Enemy1X = 10'(vecs[i].ex); Enemy1Y = 10'(vecs[i].ey);
      EnemyX = 10'd500; EnemyY = 10'd1023;
      keycode = 8'd19;
      step();
      keycode = 8'd0;
      step();
      check($sformatf("t3_win%0d_hit", i), 32'(egg_hit), 32'(vecs[i].exp_hit));
      check($sformatf("t3_win%0d_dir", i), 32'(spray_dir), 32'(vecs[i].dir));
    end

    // Both enemies hit; sausage re-hit when its timer reads 100.
    do_reset();
    chef_dir = 1'b1; ChefX = 10'd300; ChefY = 10'd300;
    EnemyX = 10'd310; EnemyY = 10'd300; Enemy1X = 10'd320; Enemy1Y = 10'd302;
    keycode = 8'd19;
    step();
    for (int e = 1; e <= 1105; e++) begin
      keycode = (e == 501) ? 8'd19 : 8'd0;
      EnemyX  = (e == 1 || e == 502) ? 10'd310 : 10'd600;
      Enemy1X = (e == 1) ? 10'd320 : 10'd700;
      step();
      if (e == 1) begin
        check("t5_both_saus", 32'(sausage_hit), 32'd1);
        check("t5_both_egg", 32'(egg_hit), 32'd1);
      end
      if (e == 650)  check("t5_egg_expired", 32'(egg_hit), 32'd0);
      if (e == 700)  check("t5_reload_held", 32'(sausage_hit), 32'd1);
      if (e == 1101) check("t5_reload_last", 32'(sausage_hit), 32'd1);
      if (e == 1102) check("t5_reload_end", 32'(sausage_hit), 32'd0);
    end

    // Asynchronous reset mid-spray with timers running.
    do_reset();
    EnemyX = 10'd310; Enemy1X = 10'd320; Enemy1Y = 10'd300;
    keycode = 8'd19;
    step();
    keycode = 8'd0;
    steps(5);
    do_reset();
    keycode = 8'd19;
    step();
    check("t6_idle_spray", 32'(spraying), 32'd1);
    check("t6_idle_count", 32'(pepper_count), 32'(PINIT - 1));
    keycode = 8'd0;
    steps(50);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      keycode = ($urandom_range(3) == 0) ? 8'd19 : 8'($urandom_range(255));
      bonus_pickup = ($urandom_range(15) == 0);
      if ($urandom_range(7) == 0) chef_dir = ~chef_dir;
      cx = int'($urandom_range(1023));
      cy = int'($urandom_range(1023));
      ex  = cx + int'($urandom_range(60)) - 30;
      e1x = cx + int'($urandom_range(60)) - 30;
      ey  = cy + int'($urandom_range(12)) - 6;
      e1y = cy + int'($urandom_range(12)) - 6;
      ex  = (ex < 0) ? 0 : ((ex > 1023) ? 1023 : ex);
      e1x = (e1x < 0) ? 0 : ((e1x > 1023) ? 1023 : e1x);
      ey  = (ey < 0) ? 0 : ((ey > 1023) ? 1023 : ey);
      e1y = (e1y < 0) ? 0 : ((e1y > 1023) ? 1023 : e1y);
      ChefX = 10'(cx); ChefY = 10'(cy);
      EnemyX = 10'(ex); EnemyY = 10'(ey);
      Enemy1X = 10'(e1x); Enemy1Y = 10'(e1y);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
